// File: rtl/rgb_tone_pkg.sv
// Shared definitions for the RGB-to-tone pixel pipeline:
// output mode encodings and luma weights.
package rgb_tone_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_GREY = 2'b01,
        MODE_BIN  = 2'b10,
        MODE_BINV = 2'b11
    } mode_t;

    // Weights sum to 1 << LUMA_SH, so luma never exceeds the channel range.
    localparam int KR      = 77;
    localparam int KG      = 150;
    localparam int KB      = 29;
    localparam int LUMA_SH = 8;

endpackage

// File: rtl/rgb_tone_pipe_luma_calc.sv
// Stages 1-2 of the tone pipe: weighted products, then truncated luma sum.
// RGB, valid and SOF travel alongside so everything leaves aligned with Y.
module luma_calc
    import rgb_tone_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          i_dval,
    input  logic          i_sof,
    input  logic [DW-1:0] i_red,
    input  logic [DW-1:0] i_green,
    input  logic [DW-1:0] i_blue,
    output logic          o_dval,
    output logic          o_sof,
    output logic [DW-1:0] o_red,
    output logic [DW-1:0] o_green,
    output logic [DW-1:0] o_blue,
    output logic [DW-1:0] o_y
);

    localparam int PW = DW + LUMA_SH;
    localparam logic [PW-1:0] W_KR = PW'(KR);
    localparam logic [PW-1:0] W_KG = PW'(KG);
    localparam logic [PW-1:0] W_KB = PW'(KB);

    logic          r_vld1;
    logic          r_sof1;
    logic [PW-1:0] r_pr;
    logic [PW-1:0] r_pg;
    logic [PW-1:0] r_pb;
    logic [DW-1:0] r_red1;
    logic [DW-1:0] r_green1;
    logic [DW-1:0] r_blue1;
    logic [PW-1:0] w_sum;

    assign w_sum = r_pr + r_pg + r_pb;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_vld1   <= 1'b0;
            r_sof1   <= 1'b0;
            r_pr     <= '0;
            r_pg     <= '0;
            r_pb     <= '0;
            r_red1   <= '0;
            r_green1 <= '0;
            r_blue1  <= '0;
            o_dval   <= 1'b0;
            o_sof    <= 1'b0;
            o_red    <= '0;
            o_green  <= '0;
            o_blue   <= '0;
            o_y      <= '0;
        end else begin
            r_vld1   <= i_dval;
            r_sof1   <= i_dval & i_sof;
            r_pr     <= W_KR * PW'(i_red);
            r_pg     <= W_KG * PW'(i_green);
            r_pb     <= W_KB * PW'(i_blue);
            r_red1   <= i_red;
            r_green1 <= i_green;
            r_blue1  <= i_blue;
            o_dval   <= r_vld1;
            o_sof    <= r_sof1;
            o_red    <= r_red1;
            o_green  <= r_green1;
            o_blue   <= r_blue1;
            o_y      <= w_sum[PW-1:LUMA_SH];
        end
    end

endmodule

// File: rtl/rgb_tone_pipe.sv
// Colour-to-tone pixel pipeline: pass / grey / binary / inverted binary,
// fixed 3-cycle latency, with a per-frame above-threshold pixel count.
module rgb_tone_pipe
    import rgb_tone_pkg::*;
#(
    parameter int DW   = 12,
    parameter int CNTW = 20
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iDVAL,
    input  logic            iSOF,
    input  logic [DW-1:0]   iRED,
    input  logic [DW-1:0]   iGREEN,
    input  logic [DW-1:0]   iBLUE,
    input  logic [1:0]      iMODE,
    input  logic [DW-1:0]   iTHRESH,
    output logic            oDVAL,
    output logic            oSOF,
    output logic [DW-1:0]   oRED,
    output logic [DW-1:0]   oGREEN,
    output logic [DW-1:0]   oBLUE,
    output logic [CNTW-1:0] oABOVE_CNT,
    output logic            oCNT_VAL
);

    localparam logic [DW-1:0]   THR_RST = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]   PIX_MAX = {DW{1'b1}};
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    mode_t         r_mode_q;
    mode_t         r_mode_s2;
    logic [DW-1:0] r_thr_q;
    logic [DW-1:0] r_thr_s2;
    logic [CNTW-1:0] r_run;
    logic          r_seen_sof;

    logic          w_dval2;
    logic          w_sof2;
    logic [DW-1:0] w_red2;
    logic [DW-1:0] w_green2;
    logic [DW-1:0] w_blue2;
    logic [DW-1:0] w_y2;
    logic          w_above;
    logic [DW-1:0] w_red3;
    logic [DW-1:0] w_green3;
    logic [DW-1:0] w_blue3;

    luma_calc #(.DW(DW)) u_luma (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_dval  (iDVAL),
        .i_sof   (iSOF),
        .i_red   (iRED),
        .i_green (iGREEN),
        .i_blue  (iBLUE),
        .o_dval  (w_dval2),
        .o_sof   (w_sof2),
        .o_red   (w_red2),
        .o_green (w_green2),
        .o_blue  (w_blue2),
        .o_y     (w_y2)
    );

    // Shadow registers load alongside stage 1; the stage-2 copies travel with
    // the pixel, so a frame-boundary update never reaches pixels in flight.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_mode_q  <= MODE_PASS;
            r_thr_q   <= THR_RST;
            r_mode_s2 <= MODE_PASS;
            r_thr_s2  <= THR_RST;
        end else begin
            if (iDVAL && iSOF) begin
                r_mode_q <= mode_t'(iMODE);
                r_thr_q  <= iTHRESH;
            end
            r_mode_s2 <= r_mode_q;
            r_thr_s2  <= r_thr_q;
        end
    end

    assign w_above = (w_y2 > r_thr_s2);

    always_comb begin
        w_red3   = w_red2;
        w_green3 = w_green2;
        w_blue3  = w_blue2;
        case (r_mode_s2)
            MODE_GREY: begin
                w_red3   = w_y2;
                w_green3 = w_y2;
                w_blue3  = w_y2;
            end
            MODE_BIN: begin
                w_red3   = w_above ? PIX_MAX : '0;
                w_green3 = w_red3;
                w_blue3  = w_red3;
            end
            MODE_BINV: begin
                w_red3   = w_above ? '0 : PIX_MAX;
                w_green3 = w_red3;
                w_blue3  = w_red3;
            end
            default: ;
        endcase
    end

    // The first SOF after reset only opens a frame; a report needs a full one.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDVAL      <= 1'b0;
            oSOF       <= 1'b0;
            oRED       <= '0;
            oGREEN     <= '0;
            oBLUE      <= '0;
            oABOVE_CNT <= '0;
            oCNT_VAL   <= 1'b0;
            r_run      <= '0;
            r_seen_sof <= 1'b0;
        end else begin
            oDVAL    <= w_dval2;
            oSOF     <= w_sof2;
            oRED     <= w_dval2 ? w_red3   : '0;
            oGREEN   <= w_dval2 ? w_green3 : '0;
            oBLUE    <= w_dval2 ? w_blue3  : '0;
            oCNT_VAL <= 1'b0;
            if (w_dval2) begin
                if (w_sof2) begin
                    if (r_seen_sof) begin
                        oABOVE_CNT <= r_run;
                        oCNT_VAL   <= 1'b1;
                    end
                    r_seen_sof <= 1'b1;
                    r_run      <= CNTW'(w_above);
                end else if (w_above && (r_run != CNT_MAX)) begin
                    r_run <= r_run + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_tone_pipe.sv
// Bench for rgb_tone_pipe: cycle-indexed expectation tables filled by a
// frame-level behavioural model, plus literal pins on key pixels and counts.
module tb_rgb_tone_pipe;

    localparam int DW   = 12;
    localparam int MAXV = 4095;
    localparam int NCYC = 8192;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iDVAL = 1'b0;
    logic          iSOF = 1'b0;
    logic [DW-1:0] iRED = '0;
    logic [DW-1:0] iGREEN = '0;
    logic [DW-1:0] iBLUE = '0;
    logic [1:0]    iMODE = '0;
    logic [DW-1:0] iTHRESH = '0;

    logic          oDVAL, oSOF, oCNT_VAL;
    logic [DW-1:0] oRED, oGREEN, oBLUE;
    logic [19:0]   oABOVE_CNT;
    logic          oDVAL_b, oSOF_b, oCNT_VAL_b;
    logic [DW-1:0] oRED_b, oGREEN_b, oBLUE_b;
    logic [2:0]    oABOVE_CNT_b;

    rgb_tone_pipe #(.DW(DW), .CNTW(20)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iSOF(iSOF),
        .iRED(iRED), .iGREEN(iGREEN), .iBLUE(iBLUE),
        .iMODE(iMODE), .iTHRESH(iTHRESH),
        .oDVAL(oDVAL), .oSOF(oSOF), .oRED(oRED), .oGREEN(oGREEN), .oBLUE(oBLUE),
        .oABOVE_CNT(oABOVE_CNT), .oCNT_VAL(oCNT_VAL)
    );

    rgb_tone_pipe #(.DW(DW), .CNTW(3)) dut3 (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iSOF(iSOF),
        .iRED(iRED), .iGREEN(iGREEN), .iBLUE(iBLUE),
        .iMODE(iMODE), .iTHRESH(iTHRESH),
        .oDVAL(oDVAL_b), .oSOF(oSOF_b), .oRED(oRED_b), .oGREEN(oGREEN_b), .oBLUE(oBLUE_b),
        .oABOVE_CNT(oABOVE_CNT_b), .oCNT_VAL(oCNT_VAL_b)
    );

    always #5 iCLK = ~iCLK;

    // Expected outputs, indexed by the negedge on which they must be visible.
    int e_dv[NCYC], e_sof[NCYC], e_r[NCYC], e_g[NCYC], e_b[NCYC];
    int e_cv[NCYC], e_a20[NCYC], e_a3[NCYC];
    int l_r[NCYC], l_a20[NCYC], l_a3[NCYC];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int m_mode = 0, m_thr = 2048, m_seen = 0;
    int m_run20 = 0, m_run3 = 0, m_rep20 = 0, m_rep3 = 0;

    function automatic int luma(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic set_idle(input int idx);
        e_dv[idx] = 0;  e_sof[idx] = 0;
        e_r[idx] = 0;   e_g[idx] = 0;   e_b[idx] = 0;
        e_cv[idx] = 0;  e_a20[idx] = m_rep20; e_a3[idx] = m_rep3;
        l_r[idx] = -1;  l_a20[idx] = -1; l_a3[idx] = -1;
    endtask

    task automatic check();
        int c;
        c = cyc;
        cmp("odval", int'(oDVAL), e_dv[c]);
        cmp("osof", int'(oSOF), e_sof[c]);
        cmp("odval_w3", int'(oDVAL_b), e_dv[c]);
        if (e_dv[c] != 0) begin
            cmp("ored", int'(oRED), e_r[c]);
            cmp("ogreen", int'(oGREEN), e_g[c]);
            cmp("oblue", int'(oBLUE), e_b[c]);
            cmp("ored_w3", int'(oRED_b), e_r[c]);
        end
        cmp("cnt_val", int'(oCNT_VAL), e_cv[c]);
        cmp("above_cnt", int'(oABOVE_CNT), e_a20[c]);
        cmp("cnt_val_w3", int'(oCNT_VAL_b), e_cv[c]);
        cmp("above_cnt_w3", int'(oABOVE_CNT_b), e_a3[c]);
        if (l_r[c] >= 0)   cmp("pin_red", int'(oRED), l_r[c]);
        if (l_a20[c] >= 0) cmp("pin_above", int'(oABOVE_CNT), l_a20[c]);
        if (l_a3[c] >= 0)  cmp("pin_above_w3", int'(oABOVE_CNT_b), l_a3[c]);
    endtask

    // One input cycle: check what is visible now, drive the next pixel,
    // and record what that pixel must produce three cycles later.
    task automatic pix(input int dv, input int sof, input int r, input int g, input int b,
                       input int md, input int th,
                       input int lr = -1, input int la20 = -1, input int la3 = -1);
        int idx, y, ab, o;
        @(negedge iCLK);
        check();
        iDVAL = (dv != 0);
        iSOF = (sof != 0);
        iRED = DW'(r);
        iGREEN = DW'(g);
        iBLUE = DW'(b);
        iMODE = 2'(md);
        iTHRESH = DW'(th);
        idx = cyc + 3;
        set_idle(idx);
        if (dv != 0) begin
            if (sof != 0) begin
                m_mode = md;
                m_thr = th;
            end
            y = luma(r, g, b);
            ab = (y > m_thr) ? 1 : 0;
            e_dv[idx] = 1;
            e_sof[idx] = (sof != 0) ? 1 : 0;
            case (m_mode)
                0: begin e_r[idx] = r; e_g[idx] = g; e_b[idx] = b; end
                1: begin e_r[idx] = y; e_g[idx] = y; e_b[idx] = y; end
                2: begin o = ab ? MAXV : 0; e_r[idx] = o; e_g[idx] = o; e_b[idx] = o; end
                default: begin o = ab ? 0 : MAXV; e_r[idx] = o; e_g[idx] = o; e_b[idx] = o; end
            endcase
            if (sof != 0) begin
                if (m_seen != 0) begin
                    e_cv[idx] = 1;
                    m_rep20 = m_run20;
                    m_rep3 = m_run3;
                end
                m_run20 = ab;
                m_run3 = ab;
                m_seen = 1;
            end else begin
                if (m_run20 + ab <= 1048575) m_run20 = m_run20 + ab;
                if (m_run3 + ab <= 7) m_run3 = m_run3 + ab;
            end
            e_a20[idx] = m_rep20;
            e_a3[idx] = m_rep3;
        end
        l_r[idx] = lr;
        l_a20[idx] = la20;
        l_a3[idx] = la3;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        check();
        iRST = 1'b1;
        iDVAL = 1'b0;
        iSOF = 1'b0;
        m_mode = 0; m_thr = 2048; m_seen = 0;
        m_run20 = 0; m_run3 = 0; m_rep20 = 0; m_rep3 = 0;
        for (int k = 1; k <= 3; k++) set_idle(cyc + k);
        #1;
        cmp("rst_odval", int'(oDVAL), 0);
        cmp("rst_ored", int'(oRED), 0);
        cmp("rst_oblue", int'(oBLUE), 0);
        cmp("rst_above", int'(oABOVE_CNT), 0);
        cmp("rst_cnt_val", int'(oCNT_VAL), 0);
        cyc++;
        repeat (2) pix(0, 0, 0, 0, 0, 0, 0);
        iRST = 1'b0;
    endtask

    function automatic int rv();
        return int'($urandom_range(0, MAXV));
    endfunction

    initial begin
        int v;
        for (int i = 0; i < NCYC; i++) set_idle(i);
        repeat (3) pix(0, 0, 0, 0, 0, 0, 0);
        iRST = 1'b0;

        // Grey-mode luma of the primaries.
        pix(1, 1, 4095, 4095, 4095, 1, 2048, 4095);
        pix(1, 0, 4095, 0, 0, 1, 2048, 1231);
        pix(1, 0, 0, 4095, 0, 1, 2048, 2399);
        pix(1, 0, 0, 0, 4095, 1, 2048, 463);
        pix(0, 0, 0, 0, 0, 1, 2048);

        // Pass mode with random gaps.
        pix(1, 1, rv(), rv(), rv(), 0, 2048);
        repeat (40) pix(int'($urandom_range(0, 1)), 0, rv(), rv(), rv(), 0, 2048);

        // Binary thr 2000: 10 valid pixels, 4 above (2001, 2500, 4095, 3000).
        pix(1, 1, 2000, 2000, 2000, 2, 2000, 0);
        pix(1, 0, 2001, 2001, 2001, 2, 2000, 4095);
        pix(0, 0, rv(), rv(), rv(), 2, 2000);
        pix(1, 0, 0, 0, 0, 2, 2000, 0);
        pix(1, 0, 2500, 2500, 2500, 2, 2000, 4095);
        pix(1, 0, 1999, 1999, 1999, 2, 2000, 0);
        pix(0, 1, 4095, 4095, 4095, 2, 2000);
        pix(1, 0, 100, 100, 100, 2, 2000);
        pix(1, 0, 4095, 4095, 4095, 2, 2000);
        pix(1, 0, 1000, 1000, 1000, 2, 2000);
        pix(1, 0, 3000, 3000, 3000, 2, 2000);
        pix(1, 0, 2000, 2000, 2000, 2, 2000, 0);

        // Inverted: reports 4; then 9 above pixels saturate the 3-bit counter.
        pix(1, 1, 2000, 2000, 2000, 3, 2000, 4095, 4, 4);
        pix(1, 0, 2001, 2001, 2001, 3, 2000, 0);
        for (int k = 1; k <= 8; k++) pix(1, 0, 2001 + 100 * k, 2001 + 100 * k, 2001 + 100 * k, 3, 2000, 0);
        pix(1, 0, 5, 5, 5, 3, 2000, 4095);

        // Grey frame; a mid-frame switch to binary must wait for the next SOF.
        pix(1, 1, 3000, 3000, 3000, 1, 2000, 3000, 9, 7);
        pix(1, 0, 3000, 3000, 3000, 2, 100, 3000);
        pix(1, 0, 1500, 1500, 1500, 2, 100, 1500);
        pix(1, 1, 3000, 3000, 3000, 2, 2000, 4095);
        pix(1, 0, 1500, 1500, 1500, 1, 2000, 0);

        // One-pixel frames.
        repeat (30) pix(1, 1, rv(), rv(), rv(), int'($urandom_range(0, 3)), rv());

        // Long random run, SOF now and then, requests changing every cycle.
        repeat (500) begin
            v = int'($urandom_range(0, 99));
            pix((v < 75) ? 1 : 0, (v % 25 == 0) ? 1 : 0, rv(), rv(), rv(),
                int'($urandom_range(0, 3)), rv());
        end

        // Reset with pixels in flight; mode and threshold fall back to pass/2048.
        pix(1, 1, rv(), rv(), rv(), 1, 500);
        pix(1, 0, rv(), rv(), rv(), 1, 500);
        pix(1, 0, rv(), rv(), rv(), 1, 500);
        do_reset();
        pix(1, 0, 2049, 2049, 2049, 3, 100, 2049);
        pix(1, 0, 2048, 2048, 2048, 3, 100, 2048);
        pix(1, 1, 2049, 2049, 2049, 0, 2048);
        repeat (6) pix(int'($urandom_range(0, 1)), 0, rv(), rv(), rv(), 0, 2048);
        pix(1, 1, rv(), rv(), rv(), 1, 2048);
        repeat (20) pix(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), rv(), rv(), rv(),
                        int'($urandom_range(0, 3)), rv());
        repeat (4) pix(0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rgb_tone_pipe.md
# rgb_tone_pipe

Parametrised colour-to-tone pixel pipeline for the camera datapath, placed between the Bayer-to-RGB stage and the display/VGA path. It converts each RGB pixel to weighted luma and outputs one of four modes: passthrough, greyscale, binary, or inverted binary. The output is a fixed-latency, valid-qualified pixel stream. Mode and threshold take effect only at frame boundaries. A per-frame count of above-threshold pixels is reported for exposure and auto-threshold logic.

## Interface
Parameters:
- DW, 12: bits per colour channel.
- CNTW, 20: width of the above-threshold pixel counter.

Ports:
- iCLK  in  1  pixel clock; all logic on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iDVAL  in  1  input pixel valid.
- iSOF  in  1  start of frame; qualified by iDVAL; marks the first pixel of a frame.
- iRED / iGREEN / iBLUE  in  DW each  input channels.
- iMODE  in  2  requested mode: 00 pass, 01 grey, 10 binary, 11 binary-inverted.
- iTHRESH  in  DW  requested binary threshold.
- oDVAL  out  1  output pixel valid.
- oSOF  out  1  start-of-frame flag, aligned with oDVAL.
- oRED / oGREEN / oBLUE  out  DW each  output channels.
- oABOVE_CNT  out  CNTW  pixels with luma above threshold in the last completed frame.
- oCNT_VAL  out  1  one-cycle pulse when oABOVE_CNT updates.

## Operation
- Luma: Y = (77·R + 150·G + 29·B) >> 8.
  - Products and sum are DW+8 bits wide; the result is truncated, not rounded.
  - The weights sum to 256, so Y ≤ 2^DW−1 and no saturation is needed.
- Shadow registers mode_q and thr_q load iMODE and iTHRESH on the cycle where iDVAL & iSOF.
  - That pixel and the rest of its frame use the new values.
  - Changes to iMODE or iTHRESH mid-frame are ignored until the next iSOF.
- Output selection, per valid pixel:
  - pass: R, G and B delayed to match pipeline latency.
  - grey: all three channels = Y.
  - binary: all channels = 2^DW−1 if Y > thr_q, else 0.
  - inverted: all channels = 0 if Y > thr_q, else 2^DW−1.
  - Y == thr_q counts as "not above" in both binary modes.
- Counter:
  - Increments for each valid pixel with Y > thr_q, in every mode including pass.
  - Saturates at 2^CNTW−1.
- Frame rollover, when a valid iSOF pixel reaches stage 3:
  - oABOVE_CNT takes the running count of the previous frame.
  - oCNT_VAL pulses for one cycle.
  - The running count restarts at 1 if the SOF pixel is above threshold, else 0.
- Unqualified pixels (iDVAL=0) are ignored; their data is don't-care.
- No backpressure: the downstream must accept one pixel per cycle.

## Timing
- Three-stage pipeline, fixed latency 3 cycles: iDVAL at edge N gives oDVAL at edge N+3.
- oSOF, oRED, oGREEN and oBLUE follow the same latency.
- Stage 1 registers the three products and delayed RGB, valid and SOF. The shadow registers load at stage 1 as well.
- Stage 2 registers Y and thr_q and mode_q carried with the pixel. A shadow update therefore never affects pixels already in flight.
- Stage 3 registers the output mux, the counter and oABOVE_CNT.
- Gaps in iDVAL propagate as gaps in oDVAL; back-to-back pixels sustain 1 pixel per clock.
- Reset values:
  - All outputs 0.
  - Pipeline valids 0.
  - mode_q = pass; thr_q = 2^(DW−1).
  - Running count 0.
- Reset mid-frame flushes the pipeline; the next oCNT_VAL requires two iSOF events after reset.
- An iSOF on every pixel (1-pixel frames) must update oABOVE_CNT every cycle with the correct count of 0 or 1.

## Structure
- Package rgb_tone_pkg holds:
  - mode encodings MODE_PASS, MODE_GREY, MODE_BIN, MODE_BINV;
  - coefficients KR=77, KG=150, KB=29 and shift LUMA_SH=8.
- Sub-module luma_calc (stages 1–2) is parametrised on DW. It outputs Y with valid and sideband already aligned.
- The top level holds the shadow registers, the stage-3 mux and the counter.

## Test plan
- DW=12, grey mode, pixels (4095,4095,4095), (4095,0,0), (0,4095,0), (0,0,4095) -> oR=oG=oB = 4095, 1231, 2399, 463 respectively, each 3 cycles after input.
- Pass mode, random RGB with random iDVAL gaps -> output identical to input delayed 3 cycles; oDVAL pattern preserved.
- Binary with thr 2000:
  - Y=2000 -> 0; Y=2001 -> 4095.
  - Inverted mode gives the complement.
- iMODE switched from grey to binary mid-frame -> no change until the next iSOF pixel, which is the first binary-mode output.
- Frame of 10 valid pixels with 4 above threshold, then iSOF -> oCNT_VAL pulse with oABOVE_CNT=4. With CNTW=3 and 9 above -> 7 (saturated).
- iRST asserted with pixels in flight -> oDVAL=0 and all outputs 0 immediately; mode reverts to pass and threshold to 2048.
